// File: rtl/tennis_rally_engine_if.sv
// Player/display bus for the tennis rally core.
// master: debouncer/display side; slave: the rally engine.
interface tennis_rally_engine_if #(
   parameter int unsigned N_LEDS  = 16,
   parameter int unsigned SCORE_W = 4
);
   logic                right_hit;
   logic                left_hit;
   logic [N_LEDS-1:0]   ball;
   logic [SCORE_W-1:0]  score_right;
   logic [SCORE_W-1:0]  score_left;
   logic                point_pulse;
   logic [1:0]          winner;

   modport master (
      output right_hit, left_hit,
      input  ball, score_right, score_left, point_pulse, winner
   );

   modport slave (
      input  right_hit, left_hit,
      output ball, score_right, score_left, point_pulse, winner
   );
endinterface

// File: rtl/tennis_rally_engine.sv
// Two-player LED tennis core: a lit position bounces between the ends at a
// divided step rate, players return it inside a hit window, misses score.
// Optional feature macro: TENNIS_SPEEDUP_EN (step period shortens with the
// number of returns in the current rally; default build keeps it constant).
module tennis_rally_engine #(
   parameter int unsigned N_LEDS    = 16,
   parameter int unsigned TICK_DIV  = 8,
   parameter int unsigned HIT_WIN   = 2,
   parameter int unsigned SCORE_W   = 4,
   parameter int unsigned WIN_SCORE = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   tennis_rally_engine_if.slave bus
);
   localparam int unsigned POS_W   = $clog2(N_LEDS);
   localparam int unsigned DIV_W   = $clog2(TICK_DIV);
   localparam int unsigned PER_W   = $clog2(TICK_DIV + 1);
   localparam int unsigned QUARTER = TICK_DIV / 4;

   localparam logic [POS_W-1:0]   POS_MAX    = POS_W'(N_LEDS - 1);
   localparam logic [POS_W-1:0]   RWIN_HI    = POS_W'(HIT_WIN);
   localparam logic [POS_W-1:0]   LWIN_LO    = POS_W'(N_LEDS - 1 - HIT_WIN);
   localparam logic [N_LEDS-1:0]  BALL_RIGHT = N_LEDS'(1);
   localparam logic [N_LEDS-1:0]  BALL_LEFT  = {1'b1, {(N_LEDS-1){1'b0}}};
   localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);
   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TICK_DIV - 1);

   localparam logic SIDE_RIGHT = 1'b0;
   localparam logic SIDE_LEFT  = 1'b1;
   localparam logic DIR_DOWN   = 1'b0;
   localparam logic DIR_UP     = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RALLY = 2'd1,
      ST_POINT = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   state_t              r_state,   w_state_nxt;
   logic                r_server,  w_server_nxt;
   logic [POS_W-1:0]    r_pos,     w_pos_nxt;
   logic                r_dir,     w_dir_nxt;
   logic [DIV_W-1:0]    r_div,     w_div_nxt;
   logic [SCORE_W-1:0]  r_score_r, w_score_r_nxt;
   logic [SCORE_W-1:0]  r_score_l, w_score_l_nxt;
   logic                r_point,   w_point_nxt;
   logic [1:0]          r_winner,  w_winner_nxt;
   logic [N_LEDS-1:0]   r_ball,    w_ball_nxt;

   logic [PER_W-1:0]    w_period;
   logic                w_rhit_ok;
   logic                w_lhit_ok;
   logic                w_dir_hit;
   logic                w_step;
   logic                w_miss_left;
   logic                w_miss_right;
   logic                w_serve;
   logic [POS_W-1:0]    w_pos_step;

`ifdef TENNIS_SPEEDUP_EN
   logic [1:0]          r_returns, w_returns_nxt;
   logic [PER_W-1:0]    r_period,  w_period_nxt;

   assign w_period = r_period;
`else
   assign w_period = PER_W'(TICK_DIV);
`endif

   // Direction-qualified hits: at most one of these can be true in a cycle.
   assign w_rhit_ok = (r_state == ST_RALLY) && bus.right_hit &&
                      (r_dir == DIR_DOWN) && (r_pos < RWIN_HI);
   assign w_lhit_ok = (r_state == ST_RALLY) && bus.left_hit &&
                      (r_dir == DIR_UP) && (r_pos > LWIN_LO);

   // Direction after this cycle's hit; a coincident step already uses it.
   assign w_dir_hit = w_rhit_ok ? DIR_UP : (w_lhit_ok ? DIR_DOWN : r_dir);

   assign w_step       = (r_state == ST_RALLY) &&
                         (PER_W'(r_div) == (w_period - PER_W'(1)));
   assign w_miss_left  = w_step && (w_dir_hit == DIR_DOWN) && (r_pos == '0);
   assign w_miss_right = w_step && (w_dir_hit == DIR_UP) && (r_pos == POS_MAX);
   assign w_pos_step   = (w_dir_hit == DIR_UP) ? (r_pos + POS_W'(1))
                                               : (r_pos - POS_W'(1));

   assign w_serve = (r_server == SIDE_RIGHT) ? bus.right_hit : bus.left_hit;

   // Next-state and next-output logic for the rally FSM.
   always_comb begin
      w_state_nxt   = r_state;
      w_server_nxt  = r_server;
      w_pos_nxt     = r_pos;
      w_dir_nxt     = r_dir;
      w_div_nxt     = r_div;
      w_score_r_nxt = r_score_r;
      w_score_l_nxt = r_score_l;
      w_point_nxt   = 1'b0;
      w_winner_nxt  = r_winner;
      w_ball_nxt    = r_ball;
`ifdef TENNIS_SPEEDUP_EN
      w_returns_nxt = r_returns;
      w_period_nxt  = r_period;
`endif

      case (r_state)
         ST_IDLE: begin
            if (w_serve) begin
               w_state_nxt = ST_RALLY;
               w_div_nxt   = '0;
               if (r_server == SIDE_LEFT) begin
                  w_pos_nxt  = POS_MAX;
                  w_dir_nxt  = DIR_DOWN;
                  w_ball_nxt = BALL_LEFT;
               end else begin
                  w_pos_nxt  = '0;
                  w_dir_nxt  = DIR_UP;
                  w_ball_nxt = BALL_RIGHT;
               end
`ifdef TENNIS_SPEEDUP_EN
               w_returns_nxt = 2'd0;
               w_period_nxt  = PER_W'(TICK_DIV);
`endif
            end
         end

         ST_RALLY: begin
            w_dir_nxt = w_dir_hit;
`ifdef TENNIS_SPEEDUP_EN
            if ((w_rhit_ok || w_lhit_ok) && (r_returns != 2'd3)) begin
               w_returns_nxt = r_returns + 2'd1;
            end
            // New period only takes effect at a divider wrap.
            if (w_step) begin
               w_period_nxt = PER_W'(TICK_DIV - (32'(w_returns_nxt) * QUARTER));
            end
`endif
            if (w_step) begin
               w_div_nxt = '0;
               if (w_miss_left || w_miss_right) begin
                  w_state_nxt = ST_POINT;
                  w_ball_nxt  = '1;
                  w_point_nxt = 1'b1;
                  if (w_miss_right) begin
                     w_server_nxt = SIDE_RIGHT;
                     if (r_score_r != SCORE_WIN) begin
                        w_score_r_nxt = r_score_r + SCORE_W'(1);
                     end
                  end else begin
                     w_server_nxt = SIDE_LEFT;
                     if (r_score_l != SCORE_WIN) begin
                        w_score_l_nxt = r_score_l + SCORE_W'(1);
                     end
                  end
               end else begin
                  w_pos_nxt  = w_pos_step;
                  w_ball_nxt = N_LEDS'(1) << w_pos_step;
               end
            end else begin
               w_div_nxt = r_div + DIV_W'(1);
            end
         end

         ST_POINT: begin
            // Flash all LEDs for TICK_DIV cycles, then serve again or end the match.
            if (r_div == DIV_LAST) begin
               w_div_nxt = '0;
               if (r_score_r == SCORE_WIN) begin
                  w_state_nxt  = ST_OVER;
                  w_winner_nxt = 2'b01;
               end else if (r_score_l == SCORE_WIN) begin
                  w_state_nxt  = ST_OVER;
                  w_winner_nxt = 2'b10;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_ball_nxt  = (r_server == SIDE_LEFT) ? BALL_LEFT : BALL_RIGHT;
               end
            end else begin
               w_div_nxt = r_div + DIV_W'(1);
            end
         end

         ST_OVER: begin
            w_ball_nxt = '1;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; synchronous reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_server  <= SIDE_RIGHT;
         r_pos     <= '0;
         r_dir     <= DIR_UP;
         r_div     <= '0;
         r_score_r <= '0;
         r_score_l <= '0;
         r_point   <= 1'b0;
         r_winner  <= 2'b00;
         r_ball    <= BALL_RIGHT;
`ifdef TENNIS_SPEEDUP_EN
         r_returns <= 2'd0;
         r_period  <= PER_W'(TICK_DIV);
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_server  <= w_server_nxt;
         r_pos     <= w_pos_nxt;
         r_dir     <= w_dir_nxt;
         r_div     <= w_div_nxt;
         r_score_r <= w_score_r_nxt;
         r_score_l <= w_score_l_nxt;
         r_point   <= w_point_nxt;
         r_winner  <= w_winner_nxt;
         r_ball    <= w_ball_nxt;
`ifdef TENNIS_SPEEDUP_EN
         r_returns <= w_returns_nxt;
         r_period  <= w_period_nxt;
`endif
      end
   end

   assign bus.ball        = r_ball;
   assign bus.score_right = r_score_r;
   assign bus.score_left  = r_score_l;
   assign bus.point_pulse = r_point;
   assign bus.winner      = r_winner;
endmodule
